// File: rtl/ravenna_adc_sar_ctrl_pkg.sv
// Shared definitions for the SAR ADC controller: FSM encoding, default
// geometry/timing constants and a small constant-evaluation helper.
package ravenna_adc_sar_ctrl_pkg;

    localparam int unsigned ADC_WIDTH_DEF     = 10;
    localparam int unsigned SAMPLE_CYCLES_DEF = 8;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } sar_state_e;

    // Larger of two unsigned values; used to size the shared phase counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ravenna_sync2.sv
// Two-flop synchronizer bringing the asynchronous comparator output into the
// clk domain. Both stages reset to 0.
module ravenna_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture stage followed by a resolution stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ravenna_adc_sar_ctrl.sv
// SAR ADC controller: track/hold phase, MSB-first binary search of the trim DAC
// against the synchronized comparator, then a valid/ready result hand-off
// with a sticky overrun flag. All outputs come straight from flops.
module ravenna_adc_sar_ctrl
    import ravenna_adc_sar_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = ADC_WIDTH_DEF,
    parameter int unsigned SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             chan_in,
    input  logic             comp_in,
    output logic             chan_sel,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int unsigned CNT_W = $clog2(max_u(SAMPLE_CYCLES, SETTLE_CYCLES));
    localparam int unsigned BIT_W = $clog2(WIDTH);

    sar_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic             chan_q, chan_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             comp_sync_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] acc_dec_s;

    ravenna_sync2 u_comp_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (comp_in),
        .q_o   (comp_sync_s)
    );

    // Bit under test and the accumulator after this bit's decision.
    assign mask_s    = WIDTH'(1) << bit_q;
    assign acc_dec_s = comp_sync_s ? (acc_q | mask_s) : (acc_q & ~mask_s);

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        acc_d     = acc_q;
        dac_d     = dac_q;
        result_d  = result_q;
        sample_d  = sample_q;
        busy_d    = busy_q;
        chan_d    = chan_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        // Consumer handshake and overrun clear; DONE below may override both.
        if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chan_d   = chan_in;
                    busy_d   = 1'b1;
                    sample_d = 1'b1;
                    dac_d    = '0;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    sample_d = 1'b0;
                    bit_d    = BIT_W'(WIDTH - 1);
                    dac_d    = WIDTH'(1) << (WIDTH - 1);
                    cnt_d    = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DECIDE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DECIDE: begin
                acc_d = acc_dec_s;
                if (bit_q == '0) begin
                    dac_d   = acc_dec_s;
                    state_d = ST_DONE;
                end else begin
                    bit_d   = bit_q - BIT_W'(1);
                    dac_d   = acc_dec_s | (mask_s >> 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                result_d = acc_q;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                dac_d    = '0;
                state_d  = ST_IDLE;
                // An unconsumed result is being replaced.
                if (valid_q && !result_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_d;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                sample_d = 1'b0;
                dac_d    = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            acc_q     <= '0;
            dac_q     <= '0;
            result_q  <= '0;
            sample_q  <= 1'b0;
            busy_q    <= 1'b0;
            chan_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            acc_q     <= acc_d;
            dac_q     <= dac_d;
            result_q  <= result_d;
            sample_q  <= sample_d;
            busy_q    <= busy_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign chan_sel     = chan_q;
    assign sample       = sample_q;
    assign dac_code     = dac_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_ravenna_adc_sar_ctrl.sv
// Directed bench for the SAR ADC controller. The comparator is modelled as
// vin >= dac_code * 3.3V / 1024, evaluated in integer millivolts.
module tb_ravenna_adc_sar_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       chan_in;
    logic       comp_in;
    logic       chan_sel;
    logic       sample;
    logic [9:0] dac_code;
    logic       busy;
    logic [9:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       overrun;
    logic       overrun_clr;

    int  vin_mv;
    logic glitch;
    int  pass_cnt;
    int  total_cnt;

    ravenna_adc_sar_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .chan_in      (chan_in),
        .comp_in      (comp_in),
        .chan_sel     (chan_sel),
        .sample       (sample),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign comp_in = glitch ^ ((vin_mv * 1024) >= (int'(dac_code) * 3300));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a conversion and follow it until busy drops. lat counts clock
    // edges after the start edge.
    task automatic do_conv(input logic ch, input int mv, input bit pulse_ready,
                           input bit hold_start, output int lat,
                           output bit chan_ok, output bit samp_ok);
        chan_in = ch;
        vin_mv  = mv;
        start   = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        chan_in = ~ch;
        lat     = 0;
        chan_ok = 1'b1;
        samp_ok = 1'b1;
        while (busy === 1'b1 && lat < 200) begin
            if (chan_sel !== ch) chan_ok = 1'b0;
            if (sample !== (lat < 8)) samp_ok = 1'b0;
            if (lat == 58) begin
                if (pulse_ready) result_ready = 1'b1;
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        total_cnt++;
        if ({chan_sel, sample, dac_code, busy, result, result_valid, overrun} !== 24'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {chan_sel, sample, dac_code, busy, result, result_valid, overrun});
        else pass_cnt++;
    endtask

    task automatic test_single;
        int lat; bit cok; bit sok;
        result_ready = 1'b1;
        do_conv(1'b0, 1000, 1'b0, 1'b0, lat, cok, sok);
        total_cnt++;
        if (lat !== 59) $display("FAIL single_latency: got %0d expected 59", lat); else pass_cnt++;
        total_cnt++;
        if (result_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", result_valid); else pass_cnt++;
        total_cnt++;
        if (result !== 10'd310) $display("FAIL single_result: got %0d expected 310", result); else pass_cnt++;
        total_cnt++;
        if (cok !== 1'b1 || chan_sel !== 1'b0) $display("FAIL single_chan: got ok=%b sel=%b expected 1/0", cok, chan_sel); else pass_cnt++;
        total_cnt++;
        if (sok !== 1'b1) $display("FAIL single_sample_window: got %b expected 1", sok); else pass_cnt++;
        total_cnt++;
        if (dac_code !== 10'd0) $display("FAIL single_dac_idle: got %0d expected 0", dac_code); else pass_cnt++;
        tick();
        total_cnt++;
        if (result_valid !== 1'b0) $display("FAIL single_valid_clear: got %b expected 0", result_valid); else pass_cnt++;
    endtask

    task automatic test_channels;
        int lat; bit cok; bit sok;
        int mv_tab[3] = '{1500, 3300, 0};
        int exp_tab[3] = '{465, 1023, 0};
        result_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_conv(1'b1, mv_tab[i], 1'b0, 1'b0, lat, cok, sok);
            total_cnt++;
            if (result !== 10'(exp_tab[i]))
                $display("FAIL chan1_result_%0d: got %0d expected %0d", i, result, exp_tab[i]);
            else pass_cnt++;
            total_cnt++;
            if (cok !== 1'b1) $display("FAIL chan1_sel_%0d: got %b expected 1", i, cok); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_start_while_busy;
        int lat; bit cok; bit sok;
        result_ready = 1'b1;
        do_conv(1'b0, 1000, 1'b0, 1'b1, lat, cok, sok);
        total_cnt++;
        if (lat !== 59) $display("FAIL busy_start_latency: got %0d expected 59", lat); else pass_cnt++;
        total_cnt++;
        if (result !== 10'd310) $display("FAIL busy_start_result: got %0d expected 310", result); else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_start_single_conv: got busy=%b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat; bit cok; bit sok;
        result_ready = 1'b0;
        do_conv(1'b0, 1000, 1'b0, 1'b0, lat, cok, sok);
        do_conv(1'b1, 1500, 1'b0, 1'b0, lat, cok, sok);
        total_cnt++;
        if (lat !== 59) $display("FAIL b2b_latency: got %0d expected 59", lat); else pass_cnt++;
        total_cnt++;
        if (result !== 10'd465) $display("FAIL b2b_result: got %0d expected 465", result); else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL b2b_overrun_set: got %b expected 1", overrun); else pass_cnt++;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL b2b_overrun_clr: got %b expected 0", overrun); else pass_cnt++;
        total_cnt++;
        if (result_valid !== 1'b1) $display("FAIL b2b_valid_held: got %b expected 1", result_valid); else pass_cnt++;
        // Old result still pending; the consumer takes it in the DONE cycle.
        do_conv(1'b0, 1000, 1'b1, 1'b0, lat, cok, sok);
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL ready_at_done_overrun: got %b expected 0", overrun); else pass_cnt++;
        total_cnt++;
        if (result !== 10'd310 || result_valid !== 1'b1)
            $display("FAIL ready_at_done_result: got %0d/%b expected 310/1", result, result_valid);
        else pass_cnt++;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_mid_reset;
        int lat; bit cok; bit sok;
        result_ready = 1'b0;
        do_conv(1'b1, 1500, 1'b0, 1'b0, lat, cok, sok);
        chan_in = 1'b1;
        vin_mv  = 1500;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (30) tick();
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({chan_sel, sample, dac_code, busy, result, result_valid, overrun} !== 24'd0)
            $display("FAIL midreset_outputs: got %h expected 0",
                     {chan_sel, sample, dac_code, busy, result, result_valid, overrun});
        else pass_cnt++;
        tick(); tick();
        reset = 1'b0;
        tick();
        result_ready = 1'b1;
        do_conv(1'b0, 1000, 1'b0, 1'b0, lat, cok, sok);
        total_cnt++;
        if (lat !== 59 || result !== 10'd310)
            $display("FAIL after_reset_conv: got lat=%0d res=%0d expected 59/310", lat, result);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_glitch_trace;
        int lat;
        int k;
        int exp_dac[10] = '{512, 256, 384, 320, 288, 304, 312, 308, 310, 311};
        result_ready = 1'b1;
        chan_in = 1'b0;
        vin_mv  = 1000;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        lat = 0;
        k   = 0;
        while (busy === 1'b1 && lat < 200) begin
            if (lat >= 9 && ((lat - 9) % 5) == 0 && k < 10) begin
                total_cnt++;
                if (dac_code !== 10'(exp_dac[k]))
                    $display("FAIL trace_dac_%0d: got %0d expected %0d", k, dac_code, exp_dac[k]);
                else pass_cnt++;
                k++;
                glitch = 1'b1;
                tick();
                lat++;
                #2 glitch = 1'b0;
            end else begin
                tick();
                lat++;
            end
        end
        total_cnt++;
        if (lat !== 59 || result !== 10'd310)
            $display("FAIL glitch_result: got lat=%0d res=%0d expected 59/310", lat, result);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        reset        = 1'b1;
        start        = 1'b0;
        chan_in      = 1'b0;
        result_ready = 1'b0;
        overrun_clr  = 1'b0;
        vin_mv       = 0;
        glitch       = 1'b0;
        tick(); tick(); tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_single();
        test_channels();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        test_glitch_trace();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
